// File: rtl/mem_wb_skid_pipe_pkg.sv
// Shared types for the MEM->WB skid pipeline.
//   mem_wb_payload_t : everything the writeback stage needs from MEM.
//   skid_state_t     : occupancy of a 2-entry skid buffer.
// The PKG_* widths are the pipeline defaults. The top level refuses to
// elaborate if its parameters disagree with them.
package pipe_pkg;

  localparam int PKG_DATA_WIDTH       = 32;
  localparam int PKG_REG_ADDR_WIDTH   = 5;
  localparam int PKG_RESULT_SRC_WIDTH = 2;

  typedef struct packed {
    logic [PKG_DATA_WIDTH-1:0]       alu_result;
    logic [PKG_DATA_WIDTH-1:0]       read_data;
    logic [PKG_REG_ADDR_WIDTH-1:0]   rd;
    logic                            reg_write;
    logic [PKG_DATA_WIDTH-1:0]       pc_plus4;
    logic [PKG_RESULT_SRC_WIDTH-1:0] result_src;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_pipe_if.sv
// MEM->WB handshake bundle.
//   master : the environment side. It drives the *_m inputs, flush and ready_w,
//            and observes ready_m and the *_w outputs.
//   slave  : the pipeline register side.
// Signals:
//   flush          synchronous kill of every held entry
//   valid_m / ready_m                 upstream handshake
//   alu_result_m .. result_src_m      upstream payload
//   valid_w / ready_w                 downstream handshake
//   alu_result_w .. result_src_w      registered payload
//   reg_write_w                       write enable, already qualified by valid_w
interface mem_wb_skid_pipe_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2
);

  logic                        flush;
  logic                        valid_m;
  logic                        ready_m;
  logic [DATA_WIDTH-1:0]       alu_result_m;
  logic [DATA_WIDTH-1:0]       read_data_m;
  logic [REG_ADDR_WIDTH-1:0]   rd_m;
  logic                        reg_write_m;
  logic [DATA_WIDTH-1:0]       pc_plus4_m;
  logic [RESULT_SRC_WIDTH-1:0] result_src_m;
  logic                        valid_w;
  logic                        ready_w;
  logic [DATA_WIDTH-1:0]       alu_result_w;
  logic [DATA_WIDTH-1:0]       read_data_w;
  logic [REG_ADDR_WIDTH-1:0]   rd_w;
  logic                        reg_write_w;
  logic [DATA_WIDTH-1:0]       pc_plus4_w;
  logic [RESULT_SRC_WIDTH-1:0] result_src_w;

  modport master (
    output flush, valid_m, alu_result_m, read_data_m, rd_m, reg_write_m,
           pc_plus4_m, result_src_m, ready_w,
    input  ready_m, valid_w, alu_result_w, read_data_w, rd_w, reg_write_w,
           pc_plus4_w, result_src_w
  );

  modport slave (
    input  flush, valid_m, alu_result_m, read_data_m, rd_m, reg_write_m,
           pc_plus4_m, result_src_m, ready_w,
    output ready_m, valid_w, alu_result_w, read_data_w, rd_w, reg_write_w,
           pc_plus4_w, result_src_w
  );

endinterface

// File: rtl/mem_wb_skid_pipe_skid_buffer.sv
// skid_buffer: a generic 2-entry valid/ready register slice with flush.
//   clk, rst          clock and asynchronous active-high reset
//   flush             drop every held entry and ignore this cycle's input
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side (out_data comes from main_q)
// in_ready is a flop. It is low only in FULL, so ready never ripples
// combinationally from out_ready back to in_ready. The second entry (skid_q)
// absorbs the beat that arrives in the cycle a stall is first seen.
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state, state_next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ready_q;
  logic             up, dn;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign up        = in_valid && ready_q;
  assign dn        = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (up) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (up && dn) begin
            load_main_in = 1'b1;
          end else if (dn) begin
            state_next = EMPTY;
          end else if (up) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end
        end
        FULL: begin
          // ready_q is low here, so no upstream beat can land in this state.
          if (dn) begin
            load_main_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
      if (load_main_in)
        main_q <= in_data;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_skid_pipe.sv
// mem_wb_skid_pipe: the MEM->WB pipeline register, built on a 2-entry skid
// buffer so that a slow data memory or a busy register-file port can stall
// writeback without losing or duplicating instructions.
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  mem_wb_skid_pipe_if.slave. It carries flush, the *_m upstream
//        handshake and payload, and the *_w downstream handshake and payload.
// reg_write_w is ANDed with valid_w, so a bubble or a flushed slot never
// writes the register file, even though the stale payload bits stay in place.
module mem_wb_skid_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_wb_skid_pipe_if.slave bus
);

  // The payload struct is fixed by the package, so mismatched widths are rejected.
  if (DATA_WIDTH != PKG_DATA_WIDTH || REG_ADDR_WIDTH != PKG_REG_ADDR_WIDTH ||
      RESULT_SRC_WIDTH != PKG_RESULT_SRC_WIDTH) begin : g_width_check
    $error("mem_wb_skid_pipe parameters must match pipe_pkg widths");
  end

  localparam int WIDTH = $bits(mem_wb_payload_t);

  mem_wb_payload_t payload_in, payload_out;
  logic            out_valid;

  always_comb begin
    payload_in            = '0;
    payload_in.alu_result = bus.alu_result_m;
    payload_in.read_data  = bus.read_data_m;
    payload_in.rd         = bus.rd_m;
    payload_in.reg_write  = bus.reg_write_m;
    payload_in.pc_plus4   = bus.pc_plus4_m;
    payload_in.result_src = bus.result_src_m;
  end

  skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .in_valid (bus.valid_m),
    .in_ready (bus.ready_m),
    .in_data  (payload_in),
    .out_valid(out_valid),
    .out_ready(bus.ready_w),
    .out_data (payload_out)
  );

  assign bus.valid_w      = out_valid;
  assign bus.alu_result_w = payload_out.alu_result;
  assign bus.read_data_w  = payload_out.read_data;
  assign bus.rd_w         = payload_out.rd;
  assign bus.reg_write_w  = payload_out.reg_write & out_valid;
  assign bus.pc_plus4_w   = payload_out.pc_plus4;
  assign bus.result_src_w = payload_out.result_src;

endmodule

// File: doc/mem_wb_skid_pipe.md
Name: mem_wb_skid_pipe

Overview:
- Parametrised MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
- Lets a multi-cycle data memory, or a stalled register-file write port, back-pressure the pipe without dropping or duplicating an instruction.
- Adds flush (bubble insertion) and valid-qualified write-enable, which the plain MEM/WB register lacks.
- Sits between the MEM stage and the writeback mux/register file.

Parameters:
- DATA_WIDTH, 32, width of ALU result, read data and PC+4.
- REG_ADDR_WIDTH, 5, destination register index width.
- RESULT_SRC_WIDTH, 2, writeback mux select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- valid_m  in  1  MEM stage presents a valid instruction.
- ready_m  out  1  block can accept this cycle.
- alu_result_m  in  DATA_WIDTH  ALU result from MEM.
- read_data_m  in  DATA_WIDTH  data memory read data.
- rd_m  in  REG_ADDR_WIDTH  destination register.
- reg_write_m  in  1  register write request.
- pc_plus4_m  in  DATA_WIDTH  PC+4.
- result_src_m  in  RESULT_SRC_WIDTH  writeback select.
- valid_w  out  1  WB holds a valid instruction.
- ready_w  in  1  WB consumes this cycle.
- alu_result_w  out  DATA_WIDTH  registered payload.
- read_data_w  out  DATA_WIDTH  registered payload.
- rd_w  out  REG_ADDR_WIDTH  registered payload.
- reg_write_w  out  1  equals stored reg_write AND valid_w.
- pc_plus4_w  out  DATA_WIDTH  registered payload.
- result_src_w  out  RESULT_SRC_WIDTH  registered payload.

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0, state goes to EMPTY, and ready_m goes to 1 after the edge. Reset mid-transfer discards all held entries.
- Handshakes:
  - Upstream transfer occurs when valid_m && ready_m.
  - Downstream transfer occurs when valid_w && ready_w.
  - Payload on the *_w outputs is stable while valid_w && !ready_w.
- ready_m is a pure register output: 1 unless state is FULL. There is no combinational path from ready_w to ready_m.
- Latency: 1 cycle from upstream transfer to valid_w when the block is not stalled. Sustained throughput is 1 per cycle with ready_w held at 1.
- State EMPTY:
  - On upstream transfer, load the main register and go to ONE.
- State ONE (main register valid):
  - Upstream and downstream transfer together: load main, stay in ONE.
  - Downstream transfer only: go to EMPTY.
  - Upstream transfer only: load skid, go to FULL.
  - Neither: hold.
- State FULL (main and skid valid, ready_m = 0):
  - Downstream transfer: skid moves to main, go to ONE.
  - Otherwise hold. No upstream accept occurs in this state.
- Flush:
  - Next state is EMPTY and valid_w = 0.
  - Any upstream transfer in the same cycle is discarded.
  - Flush takes priority over all other events.
  - Payload registers may keep stale data, but reg_write_w = 0.
- reg_write_w is gated by valid_w, so a bubble never writes the register file.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.

Decomposition:
- Package pipe_pkg holds:
  - typedef mem_wb_payload_t, a packed struct of {alu_result, read_data, rd, reg_write, pc_plus4, result_src}, widths taken from package localparams matching the defaults;
  - enum skid_state_t {EMPTY, ONE, FULL}.
- One natural sub-module: skid_buffer #(WIDTH), a generic 2-entry valid/ready buffer with flush.
- mem_wb_skid_pipe packs the *_m inputs into mem_wb_payload_t, instantiates skid_buffer with WIDTH = $bits(mem_wb_payload_t), and applies the reg_write gating.
- skid_buffer is reusable for the IF/ID, ID/EX and EX/MEM successors.

Test Plan:
- Reset release, then valid_m = 1 with alu_result_m = 32'h0000_00AA and ready_w = 1 -> next cycle valid_w = 1, alu_result_w = 32'hAA; reg_write_w follows reg_write_m.
- Stream 8 instructions, rd_m = 1..8, with ready_w held at 1 -> rd_w = 1..8 on consecutive cycles, ready_m stays 1 throughout.
- ready_w = 0 while sending A (rd = 3) then B (rd = 4):
  - state reaches FULL and ready_m = 0, outputs hold A;
  - raise ready_w -> A then B appear in order, nothing lost or duplicated.
- flush asserted in FULL, together with valid_m = 1 -> next cycle valid_w = 0, reg_write_w = 0, ready_m = 1; the flushed entries never appear.
- Assert rst asynchronously mid-cycle in ONE with reg_write_w = 1 -> valid_w and reg_write_w drop to 0 immediately, without waiting for a clock edge.
- Random valid_m and ready_w, 10k cycles, checked against a scoreboard queue -> in-order delivery, payload stable while stalled, reg_write_w never 1 while valid_w = 0.
